// File: rtl/blockram_burst_if.sv
// blockram_burst_if: pipeconnect memory bus between a master and the block RAM slave
interface blockram_burst_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_BITS = 2
);
  logic mem_waitrequest;
  logic [ID_BITS-1:0] mem_id;
  logic [29:0] mem_address;
  logic mem_read;
  logic mem_write;
  logic [DATA_WIDTH-1:0] mem_writedata;
  logic [DATA_WIDTH/8-1:0] mem_writedatamask;
  logic [DATA_WIDTH-1:0] mem_readdata;
  logic [ID_BITS-1:0] mem_readdataid;
  modport master (
    input mem_waitrequest, mem_readdata, mem_readdataid,
    output mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
  );
  modport slave (
    output mem_waitrequest, mem_readdata, mem_readdataid,
    input mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
  );
endinterface

// File: rtl/blockram_burst.sv
// blockram_burst: windowed on-chip RAM slave serving linear/wrapping read and write bursts
module blockram_burst #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE = 18,
  parameter int BURST_BITS = 2,
  parameter int ID_BITS = 2,
  parameter int SEL_BITS = 4,
  parameter int SEL_VALUE = 4,
  parameter int READ_LATENCY = 1,
  parameter int WRAP = 0,
  parameter int WRITE_BURST = 0,
  parameter string INIT_FILE = ""
) (
  input logic clock,
  input logic rst,
  blockram_burst_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_t;
  state_t state, state_n;
  logic [BURST_BITS-1:0] cnt, cnt_n;
  logic [SIZE-1:0] base, addr, burst_addr;
  logic [ID_BITS-1:0] tid, id_n, id_q;
  logic sel, we;
  logic [DATA_WIDTH-1:0] ram [2**SIZE];
  logic [DATA_WIDTH-1:0] rdata_q;
  assign sel = bus.mem_address[29 -: SEL_BITS] == SEL_BITS'(SEL_VALUE);
  assign burst_addr = WRAP != 0 ? {base[SIZE-1:BURST_BITS], base[BURST_BITS-1:0] + cnt} : base + SIZE'(cnt);
  assign bus.mem_waitrequest = state == RBURST;
  // next state, RAM address/write enable and id to launch into the read pipeline
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    addr = burst_addr;
    we = 1'b0;
    id_n = '0;
    if (state == IDLE) begin
      addr = bus.mem_address[SIZE-1:0];
      cnt_n = BURST_BITS'(1);
      we = sel && bus.mem_write;
      id_n = (sel && bus.mem_read && !bus.mem_write) ? bus.mem_id : '0;
      state_n = (sel && bus.mem_write) ? (WRITE_BURST != 0 ? WBURST : IDLE) :
                (sel && bus.mem_read) ? RBURST : IDLE;
    end else if (state == RBURST) begin
      id_n = tid;
      state_n = &cnt ? IDLE : RBURST;
    end else begin
      we = bus.mem_write;
      cnt_n = bus.mem_write ? cnt + 1'b1 : cnt;
      state_n = (bus.mem_write && &cnt) ? IDLE : WBURST;
    end
  end
  // control state; burst base and id are captured whenever a new request can start
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      base <= '0;
      tid <= '0;
      id_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      id_q <= id_n;
      if (state == IDLE) begin
        base <= bus.mem_address[SIZE-1:0];
        tid <= bus.mem_id;
      end
    end
  end
  // byte-masked RAM write and registered read (contents are never reset)
  always_ff @(posedge clock) begin
    for (int b = 0; b < DATA_WIDTH/8; b++)
      if (we && bus.mem_writedatamask[b]) ram[addr][b*8 +: 8] <= bus.mem_writedata[b*8 +: 8];
    rdata_q <= ram[addr];
  end
  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rdata2;
    logic [ID_BITS-1:0] id2;
    // extra output stage for timing; data and id advance together
    always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
        rdata2 <= '0;
        id2 <= '0;
      end else begin
        rdata2 <= rdata_q;
        id2 <= id_q;
      end
    end
    assign bus.mem_readdata = rdata2;
    assign bus.mem_readdataid = id2;
  end else begin : g_lat1
    assign bus.mem_readdata = rdata_q;
    assign bus.mem_readdataid = id_q;
  end
endmodule
